// File: rtl/alog_arbiter_if.sv
// Handshake bundle between NREQ requesters, the shared antilog converter and
// its single downstream consumer.
interface alog_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*19-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [19:0]        out_data;
    logic [IDW-1:0]     out_id;
    logic               out_ovf;

    // Arbiter side: accepts requests, produces results.
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, out_ovf
    );

    // Requester / consumer side.
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_ovf
    );
endinterface

// File: rtl/alog_arbiter.sv
// Round-robin arbiter in front of a single-stage antilog converter.
// A request grants at most one requester per cycle; the converted value is
// registered, so the result appears exactly one cycle after acceptance.
// The ready path depends only on valids, the pointer and output occupancy.
// IDW is expected to equal $clog2(NREQ).
module alog_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    alog_arbiter_if.slave bus
);

    // Log (s7.12) -> linear (1,19). Exponents above 0 flag overflow and
    // return 0; exponents below -19 shift every bit out and return 0.
    function automatic logic [19:0] alog_conv(input logic [18:0] d);
        logic signed [6:0] e;
        logic signed [6:0] neg;
        logic [19:0]       m;
        e   = d[18:12];
        neg = -e;
        m   = {1'b1, d[11:0], 7'b0};
        if (e > 7'sd0 || e < -7'sd19)
            return 20'd0;
        return m >> neg[4:0];
    endfunction

    logic [IDW-1:0]  p_q, p_d;
    logic            out_valid_q, out_valid_d;
    logic [19:0]     out_data_q, out_data_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic            out_ovf_q, out_ovf_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] gnt_oh;
    logic            out_free;
    logic            accept;
    logic [18:0]     gnt_data;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_oh    = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(p_q) + k) % NREQ;
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found   = 1'b1;
                gnt_id      = IDW'(idx);
                gnt_oh[idx] = 1'b1;
            end
        end
    end

    // Ready only when the output register can take a new result; never in reset.
    always_comb begin
        out_free      = !out_valid_q || bus.out_ready;
        accept        = gnt_found && out_free && !rst;
        bus.req_ready = accept ? gnt_oh : '0;
        gnt_data      = bus.req_data[19*int'(gnt_id) +: 19];
    end

    // Next state: load on accept, drain when taken, otherwise hold.
    always_comb begin
        p_d         = p_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_ovf_d   = out_ovf_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = alog_conv(gnt_data);
            out_id_d    = gnt_id;
            out_ovf_d   = ($signed(gnt_data[18:12]) > 7'sd0);
            p_d         = (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Drive the interface outputs from the registers.
    always_comb begin
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_id    = out_id_q;
        bus.out_ovf   = out_ovf_q;
    end

endmodule

// File: tb/tb_alog_arbiter.sv
// Directed bench for alog_arbiter: conversion vectors, round-robin order,
// backpressure hold and reset under backpressure.
module tb_alog_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alog_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

    alog_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Inputs change at negedge; one step = through the next posedge to the next negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_all(input logic [18:0] d);
        bus.req_data = {d, d, d, d};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [18:0] v_in  [5] = '{19'h00000, 19'h7F000, 19'h79800, 19'h6D000, 19'h01000};
    logic [19:0] v_out [5] = '{20'h80000, 20'h40000, 20'h01800, 20'h00001, 20'h00000};
    logic        v_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  ord32 [3] = '{2'd1, 2'd3, 2'd1};

    initial begin
        bus.req_valid = 4'hF;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        #1 chk("rst_ready", 32'(bus.req_ready), 32'h0);
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_data",  32'(bus.out_data),  32'h0);
        chk("rst_id",    32'(bus.out_id),    32'h0);
        chk("rst_ovf",   32'(bus.out_ovf),   32'h0);
        bus.req_valid = 4'h0;
        rst = 1'b0;
        step();
        chk("idle_valid", 32'(bus.out_valid), 32'h0);

        // Single requester 0 conversion vectors.
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 4'b0001;
            set_all(v_in[i]);
            #1 chk($sformatf("conv%0d_ready", i), 32'(bus.req_ready), 32'h1);
            step();
            chk($sformatf("conv%0d_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("conv%0d_data", i),  32'(bus.out_data),  32'(v_out[i]));
            chk($sformatf("conv%0d_id", i),    32'(bus.out_id),    32'h0);
            chk($sformatf("conv%0d_ovf", i),   32'(bus.out_ovf),   32'(v_ovf[i]));
        end
        bus.req_valid = 4'b0000;
        step();
        chk("drain_valid", 32'(bus.out_valid), 32'h0);

        // Underflow: e = -20.
        bus.req_valid = 4'b0001;
        set_all(19'h6C000);
        step();
        chk("uflow_valid", 32'(bus.out_valid), 32'h1);
        chk("uflow_data",  32'(bus.out_data),  32'h0);
        chk("uflow_ovf",   32'(bus.out_ovf),   32'h0);
        bus.req_valid = 4'b0000;
        step();

        // All requesters valid: round-robin 0,1,2,3,... with no bubble.
        // Requester i carries e = -i, so its result is 0x80000 >> i.
        do_reset();
        bus.req_data = {7'h7D, 12'h0, 7'h7E, 12'h0, 7'h7F, 12'h0, 7'h00, 12'h0};
        bus.req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("rr%0d_ready", i), 32'(bus.req_ready), 32'(1 << (i % 4)));
            step();
            chk($sformatf("rr%0d_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("rr%0d_id", i),    32'(bus.out_id),    32'(i % 4));
            chk($sformatf("rr%0d_data", i),  32'(bus.out_data),  32'h80000 >> (i % 4));
        end
        bus.req_valid = 4'h0;
        step();

        // Requesters 1 and 3 only, pointer starting at 0.
        do_reset();
        set_all(19'h00000);
        bus.req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("sp%0d_ready", i), 32'(bus.req_ready), 32'(1 << ord32[i]));
            step();
            chk($sformatf("sp%0d_id", i), 32'(bus.out_id), 32'(ord32[i]));
        end
        bus.req_valid = 4'h0;
        step();

        // Backpressure with 0x40000 / id 2 pending.
        do_reset();
        set_all(19'h7F000);
        bus.req_valid = 4'hF;
        step();
        step();
        #1 chk("bp_pre_ready", 32'(bus.req_ready), 32'h4);
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("bp%0d_ready", i), 32'(bus.req_ready), 32'h0);
            step();
            chk($sformatf("bp%0d_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("bp%0d_data", i),  32'(bus.out_data),  32'h40000);
            chk($sformatf("bp%0d_id", i),    32'(bus.out_id),    32'h2);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_rel_ready", 32'(bus.req_ready), 32'h8);
        step();
        chk("bp_rel_id",    32'(bus.out_id),    32'h3);
        chk("bp_rel_valid", 32'(bus.out_valid), 32'h1);

        // Reset while a result is held under backpressure.
        bus.out_ready = 1'b0;
        step();
        rst = 1'b1;
        #1 chk("rbp_ready", 32'(bus.req_ready), 32'h0);
        step();
        rst = 1'b0;
        chk("rbp_valid", 32'(bus.out_valid), 32'h0);
        chk("rbp_data",  32'(bus.out_data),  32'h0);
        #1 chk("rbp_next_ready", 32'(bus.req_ready), 32'h1);
        step();
        chk("rbp_next_id",    32'(bus.out_id),    32'h0);
        chk("rbp_next_valid", 32'(bus.out_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alog_arbiter.md
ALOG_ARBITER -- requirements
Module: alog_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the antilog converter.
REQ-002 Parameter IDW, default 2, requester-ID width; SHALL equal ceil(log2(NREQ)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_data  input  NREQ*19  per-requester signed log value; slice i = bits [19*i+18:19*i]; bits [18:12] two's-complement exponent e, bits [11:0] fraction.
REQ-007 req_ready  output  NREQ  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 out_valid  output  1  converted result valid.
REQ-009 out_ready  input  1  downstream accept; a transfer occurs when out_valid and out_ready are both high.
REQ-010 out_data  output  20  unsigned linear result, (1,19) format.
REQ-011 out_id  output  IDW  index of the requester that produced out_data.
REQ-012 out_ovf  output  1  high when the converted request had e > 0.

Function
REQ-013 Conversion: f = {1, data[11:0]} (13 bits); for -19 <= e <= 0, result = (f << 7) >> (-e), truncated to 20 bits; for e > 0 or e < -19, result = 0.
REQ-014 out_ovf SHALL be 1 iff e > 0; e < -19 is underflow, gives result 0 and out_ovf = 0.
REQ-015 Arbitration SHALL be round-robin over requesters with req_valid high, using a priority pointer P (IDW bits).
REQ-016 Search order: P, P+1, ..., P+NREQ-1 modulo NREQ; the first requester with req_valid high is granted.
REQ-017 At most one req_ready bit SHALL be high per cycle; req_ready[g] = 1 only for granted g, and only when the output register is free (out_valid == 0 or out_ready == 1).
REQ-018 req_ready is combinational from req_valid, P, out_valid and out_ready; it SHALL NOT depend on req_data.
REQ-019 On an accepted request from g: next cycle out_valid = 1, out_data = conversion of req_data[g], out_id = g, out_ovf per REQ-014, and P <= (g+1) mod NREQ.
REQ-020 Latency from request acceptance to out_valid SHALL be exactly 1 cycle; throughput 1 result/cycle while out_ready stays high.
REQ-021 With out_valid = 1 and out_ready = 0: out_data, out_id and out_ovf SHALL hold stable, all req_ready SHALL be 0, and P SHALL not change.
REQ-022 Output taken with no new acceptance in the same cycle: out_valid <= 0 next cycle.
REQ-023 Output taken and new request accepted in the same cycle: out_valid stays 1 and the new result replaces the old one with no bubble.
REQ-024 P SHALL change only on an accepted request; idle cycles leave P unchanged.
REQ-025 A requester dropping req_valid before acceptance SHALL lose no state; the arbiter keeps no per-requester memory other than P.
REQ-026 Wrap-around: a grant of NREQ-1 sets P = 0.

Reset
REQ-027 While rst is high at a clock edge: out_valid <= 0, out_data <= 0, out_id <= 0, out_ovf <= 0, P <= 0.
REQ-028 req_ready SHALL be all-zero in any cycle where rst is high.
REQ-029 Reset asserted with out_valid = 1 under backpressure SHALL discard the pending result; no stale output after reset.

Verification
REQ-030 Single requester 0 sends 0x00000, 0x7F000, 0x79800, 0x6D000, 0x01000 with out_ready = 1 -> results 0x80000, 0x40000, 0x01800, 0x00001, 0x00000 (ovf = 1 only on the last), each 1 cycle after acceptance, out_id = 0.
REQ-031 All 4 req_valid held high and out_ready = 1 from reset -> grant order 0,1,2,3,0,1,...; one result per cycle; out_id follows the same sequence.
REQ-032 Requesters 1 and 3 valid, P = 0 -> grant 1, then 3, then 1; requesters 0 and 2 never granted.
REQ-033 out_ready = 0 for 5 cycles with result 0x40000/id 2 pending and all requests valid -> output held stable, req_ready = 0, P unchanged; on release, the next grant is 3.
REQ-034 rst pulsed for 1 cycle while out_valid = 1 and out_ready = 0 -> out_valid = 0 next cycle; next grant with all requests valid goes to requester 0.
REQ-035 Data 0x6C000 (e = -20) -> out_data = 0, out_ovf = 0.
